// File: rtl/tick_scheduler_if.sv
// Config and output bundle for tick_scheduler: valid/ready channel programming
// plus the shared divider counter and per-channel strobes.
interface tick_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CNT_PW = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic              cfg_start;
  logic              cfg_mode;
  logic [4:0]        cfg_tap;
  logic [CNT_PW-1:0] cfg_count;
  logic [CNT_W-1:0]  divided_clocks;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] done;

  modport master (
    output cfg_valid, cfg_ch, cfg_start, cfg_mode, cfg_tap, cfg_count,
    input  cfg_ready, divided_clocks, tick, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_start, cfg_mode, cfg_tap, cfg_count,
    output cfg_ready, divided_clocks, tick, busy, done
  );
endinterface

// File: rtl/tick_scheduler.sv
// Free-running divider shared by NUM_CH tick channels; each channel strobes on the
// rising edge of its selected counter bit, periodically or for a counted burst.
module tick_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CNT_PW = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  tick_scheduler_if.slave  cfg
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [NUM_CH-1:0] done_q;
  state_t            state_q [NUM_CH];
  logic              mode_q  [NUM_CH];
  logic [4:0]        tap_q   [NUM_CH];
  logic [CNT_PW-1:0] rem_q   [NUM_CH];
  logic [NUM_CH-1:0] tick_w;
  logic [NUM_CH-1:0] busy_w;
  logic              accept;

  // Rising edge of bit tap: low bits [tap:0] equal exactly 1<<tap.
  function automatic logic tap_hit(input logic [CNT_W-1:0] cnt, input logic [4:0] tap);
    logic [CNT_W-1:0] mask;
    mask = (CNT_W'(2) << tap) - CNT_W'(1);
    return (cnt & mask) == (CNT_W'(1) << tap);
  endfunction

  function automatic logic [4:0] clamp_tap(input logic [4:0] t);
    if (int'(t) > CNT_W - 1) return 5'(CNT_W - 1);
    return t;
  endfunction

  assign accept  = cfg.cfg_valid & ready_q;
  assign cnt_d   = cnt_q + CNT_W'(1);
  assign ready_d = ~accept;

  always_comb begin
    tick_w = '0;
    busy_w = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      busy_w[c] = (state_q[c] == RUN);
      tick_w[c] = (state_q[c] == RUN) && tap_hit(cnt_q, tap_q[c]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= IDLE;
        mode_q[c]  <= 1'b0;
        tap_q[c]   <= '0;
        rem_q[c]   <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      for (int c = 0; c < NUM_CH; c++) begin
        done_q[c] <= 1'b0;
        // A config to this channel wins over the same-cycle tick's bookkeeping.
        if (accept && cfg.cfg_ch == CH_W'(c)) begin
          if (cfg.cfg_start) begin
            mode_q[c] <= cfg.cfg_mode;
            tap_q[c]  <= clamp_tap(cfg.cfg_tap);
            rem_q[c]  <= cfg.cfg_count;
            if (cfg.cfg_mode && cfg.cfg_count == '0) begin
              state_q[c] <= IDLE;
              done_q[c]  <= 1'b1;
            end else begin
              state_q[c] <= RUN;
            end
          end else begin
            state_q[c] <= IDLE;
          end
        end else if (tick_w[c] && mode_q[c]) begin
          if (rem_q[c] == CNT_PW'(1)) begin
            state_q[c] <= IDLE;
            done_q[c]  <= 1'b1;
          end else begin
            rem_q[c] <= rem_q[c] - CNT_PW'(1);
          end
        end
      end
    end
  end

  assign cfg.cfg_ready      = ready_q;
  assign cfg.divided_clocks = cnt_q;
  assign cfg.tick           = tick_w;
  assign cfg.busy           = busy_w;
  assign cfg.done           = done_q;
endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler; an 8-bit counter keeps the wrap and
// tap-clamp cases reachable in a few hundred cycles.
module tb_tick_scheduler;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int CNT_PW = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  tick_scheduler_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CNT_PW(CNT_PW)) bus ();

  tick_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CNT_PW(CNT_PW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .cfg     (bus)
  );

  int          n_run  = 0;
  int          n_fail = 0;
  int          idx    = 0;
  logic [63:0] tk_h [NUM_CH];
  logic [63:0] dn_h [NUM_CH];
  logic [63:0] bz_h [NUM_CH];
  logic [63:0] rdy_h;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_hist();
    idx   = 0;
    rdy_h = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      tk_h[c] = '0;
      dn_h[c] = '0;
      bz_h[c] = '0;
    end
  endtask

  // Sample the current cycle into the histories, then advance one clock.
  task automatic cyc();
    if (idx < 64) begin
      rdy_h[idx] = bus.cfg_ready;
      for (int c = 0; c < NUM_CH; c++) begin
        tk_h[c][idx] = bus.tick[c];
        dn_h[c][idx] = bus.done[c];
        bz_h[c][idx] = bus.busy[c];
      end
      idx++;
    end
    step();
  endtask

  task automatic wait_cnt(input logic [CNT_W-1:0] v);
    int k;
    k = 0;
    while (bus.divided_clocks !== v && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) check_eq("wait_cnt timeout", 64'(bus.divided_clocks), 64'(v));
  endtask

  task automatic drive(input logic [1:0] ch, input logic start, input logic mode,
                       input logic [4:0] tap, input logic [7:0] count);
    bus.cfg_valid = 1'b1;
    bus.cfg_ch    = ch;
    bus.cfg_start = start;
    bus.cfg_mode  = mode;
    bus.cfg_tap   = tap;
    bus.cfg_count = count;
  endtask

  task automatic idle_bus();
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_start = 1'b0;
    bus.cfg_mode  = 1'b0;
    bus.cfg_tap   = '0;
    bus.cfg_count = '0;
    step();
    step();
    reset_n = 1'b1;

    // Reset release state
    check_eq("rst cnt",   64'(bus.divided_clocks), 64'd0);
    check_eq("rst tick",  64'(bus.tick), 64'd0);
    check_eq("rst busy",  64'(bus.busy), 64'd0);
    check_eq("rst done",  64'(bus.done), 64'd0);
    check_eq("rst ready", 64'(bus.cfg_ready), 64'd1);
    step();
    check_eq("cnt 1", 64'(bus.divided_clocks), 64'd1);

    // Periodic ch0 tap=2 accepted at counter 1
    drive(2'd0, 1'b1, 1'b0, 5'd2, 8'd0);
    step();
    idle_bus();
    check_eq("p cnt 2",   64'(bus.divided_clocks), 64'd2);
    check_eq("p ready2",  64'(bus.cfg_ready), 64'd0);
    check_eq("p busy0",   64'(bus.busy), 64'h1);
    check_eq("p tick2",   64'(bus.tick), 64'd0);
    step();
    check_eq("p ready3",  64'(bus.cfg_ready), 64'd1);
    check_eq("p tick3",   64'(bus.tick), 64'd0);
    step();
    check_eq("p tick4",   64'(bus.tick), 64'h1);
    step();
    check_eq("p tick5",   64'(bus.tick), 64'd0);
    clr_hist();
    for (int i = 0; i < 32; i++) cyc();
    check_eq("p tick0 5..36", tk_h[0] & 64'hFFFF_FFFF, 64'h8080_8080);
    check_eq("p done0 5..36", dn_h[0] & 64'hFFFF_FFFF, 64'h0);

    // Burst ch1 tap=0 count=3 accepted at 42
    wait_cnt(8'd42);
    drive(2'd1, 1'b1, 1'b1, 5'd0, 8'd3);
    clr_hist();
    cyc();
    idle_bus();
    for (int i = 0; i < 8; i++) cyc();
    check_eq("b tick1", tk_h[1] & 64'h1FF, 64'h2A);
    check_eq("b done1", dn_h[1] & 64'h1FF, 64'h40);
    check_eq("b busy1", bz_h[1] & 64'h1FF, 64'h3E);

    // Restart ch1 on its 2nd tick, stop ch0 mid-run
    wait_cnt(8'd52);
    clr_hist();
    drive(2'd1, 1'b1, 1'b1, 5'd0, 8'd3);
    cyc();
    idle_bus();
    cyc();
    cyc();
    check_eq("r tick1 at 55", 64'(bus.tick[1]), 64'd1);
    drive(2'd1, 1'b1, 1'b1, 5'd0, 8'd5);
    cyc();
    idle_bus();
    cyc();
    drive(2'd0, 1'b0, 1'b0, 5'd0, 8'd0);
    cyc();
    idle_bus();
    for (int i = 0; i < 14; i++) cyc();
    check_eq("r tick1", tk_h[1] & 64'hFFFFF, 64'h2AAA);
    check_eq("r done1", dn_h[1] & 64'hFFFFF, 64'h4000);
    check_eq("r busy1", bz_h[1] & 64'hFFFFF, 64'h3FFE);
    check_eq("r tick0", tk_h[0] & 64'hFFFFF, 64'h1);
    check_eq("r busy0", bz_h[0] & 64'hFFFFF, 64'h3F);
    check_eq("r done0", dn_h[0] & 64'hFFFFF, 64'h0);

    // Held cfg_valid across ch0..ch3
    wait_cnt(8'd72);
    clr_hist();
    for (int c = 0; c < 4; c++) begin
      drive(2'(c), 1'b1, 1'b0, 5'd3, 8'd0);
      cyc();
    end
    idle_bus();
    check_eq("h ready", rdy_h & 64'hF, 64'h5);
    check_eq("h busy",  64'(bus.busy), 64'h5);

    // Tap 31 clamps to the top counter bit
    wait_cnt(8'd78);
    drive(2'd3, 1'b1, 1'b0, 5'd31, 8'd0);
    step();
    idle_bus();
    wait_cnt(8'h7F);
    check_eq("clamp tick 7F", 64'(bus.tick[3]), 64'd0);
    step();
    check_eq("clamp tick 80", 64'(bus.tick[3]), 64'd1);
    step();
    check_eq("clamp tick 81", 64'(bus.tick[3]), 64'd0);

    // Burst with zero count
    wait_cnt(8'h82);
    drive(2'd1, 1'b1, 1'b1, 5'd0, 8'd0);
    step();
    idle_bus();
    check_eq("z done1", 64'(bus.done[1]), 64'd1);
    check_eq("z busy1", 64'(bus.busy[1]), 64'd0);
    check_eq("z tick1", 64'(bus.tick[1]), 64'd0);
    step();
    check_eq("z done1 end", 64'(bus.done[1]), 64'd0);

    // Reset mid-burst at F0
    wait_cnt(8'hE0);
    drive(2'd0, 1'b1, 1'b1, 5'd2, 8'd5);
    step();
    idle_bus();
    wait_cnt(8'hF0);
    check_eq("mr busy0 pre", 64'(bus.busy[0]), 64'd1);
    reset_n = 1'b0;
    #1;
    check_eq("mr cnt",   64'(bus.divided_clocks), 64'd0);
    check_eq("mr busy",  64'(bus.busy), 64'd0);
    check_eq("mr tick",  64'(bus.tick), 64'd0);
    check_eq("mr done",  64'(bus.done), 64'd0);
    check_eq("mr ready", 64'(bus.cfg_ready), 64'd1);
    step();
    step();
    check_eq("mr hold cnt", 64'(bus.divided_clocks), 64'd0);
    reset_n = 1'b1;
    clr_hist();
    for (int i = 0; i < 8; i++) cyc();
    check_eq("mr post done0", dn_h[0] & 64'hFF, 64'h0);
    check_eq("mr post busy0", bz_h[0] & 64'hFF, 64'h0);

    // Counter wrap with tap=0 periodic
    wait_cnt(8'h10);
    drive(2'd1, 1'b1, 1'b0, 5'd0, 8'd0);
    step();
    idle_bus();
    wait_cnt(8'hFC);
    clr_hist();
    for (int i = 0; i < 8; i++) cyc();
    check_eq("w tick1", tk_h[1] & 64'hFF, 64'hAA);
    check_eq("w cnt",   64'(bus.divided_clocks), 64'd4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Owns the free-running divider counter and shares it between NUM_CH consumers (LED scanners, game timers, debouncers).
- Each channel is programmed through a single valid/ready config port with a tap (divider bit), a mode and a pulse count.
- Each channel emits single-cycle clock-enable strobes locked to the rising edge of its tap.
- Downstream logic runs on the one system clock and gates on tick[c]; no derived clocks leave this block.

Parameters:
NUM_CH, 4, number of independent tick channels
CNT_W, 32, divider counter width
CNT_PW, 8, burst pulse-count width

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cfg_valid  in  1  config request
cfg_ready  out  1  config port can accept
cfg_ch  in  clog2(NUM_CH)  target channel
cfg_start  in  1  1 = start/restart channel, 0 = stop channel
cfg_mode  in  1  0 = periodic, 1 = burst
cfg_tap  in  5  counter bit whose rising edge generates ticks
cfg_count  in  CNT_PW  burst length in ticks
divided_clocks  out  CNT_W  free-running counter value
tick  out  NUM_CH  per-channel one-cycle strobe
busy  out  NUM_CH  channel in RUN
done  out  NUM_CH  one-cycle pulse at end of burst

Behaviour:
Reset:
- reset_n=0 asynchronously clears divided_clocks, all channel state, tick, busy and done.
- cfg_ready is 1 at reset release.
- Reset mid-burst aborts the burst; no done pulse.
Counter:
- divided_clocks increments by 1 every clock and wraps from all-ones to 0 with no side effects.
Config handshake:
- A config is accepted when cfg_valid & cfg_ready.
- cfg_ready drops to 0 for exactly the cycle after each accept (the apply cycle), then returns to 1.
- Therefore a held cfg_valid is accepted every second cycle.
- cfg_tap > CNT_W-1 is clamped to CNT_W-1.
Channel FSM (states IDLE, RUN):
- Accept with cfg_start=1: latch tap/mode/count, rem <= cfg_count, state <= RUN. Takes effect the cycle after accept.
- Accept with cfg_start=1 while already RUN: restart with the new settings and reload rem. No done pulse.
- Burst with cfg_count=0: channel stays or returns to IDLE, no ticks, done pulses in the cycle after accept.
- Accept with cfg_start=0: state <= IDLE next cycle. No done pulse.
Tick generation:
- tick[c] = (state==RUN) & (divided_clocks[tap:0] == 1<<tap). Combinational from registers; zero latency from the counter value.
- Period is 2^(tap+1) cycles.
- The first tick after entering RUN is the next matching counter value; ticks are never phase-reset.
Burst mode:
- Each tick decrements rem.
- A tick with rem==1 is the final tick: state <= IDLE and done[c]=1 in the following cycle.
- Periodic mode never asserts done.
busy[c] = (state==RUN).
Simultaneous events:
- A config that hits channel c in the same cycle as tick[c] does not suppress that tick.
- The config overrides that tick's decrement or finish: new rem is loaded, and if the tick was final, no done is issued.
Other channels are unaffected by any config to channel c.

Test Plan:
1. Reset release, no config -> divided_clocks counts 0,1,2,...; tick, busy and done all 0; cfg_ready=1.
2. Periodic ch0, tap=2, accepted at counter=1 -> busy0=1 from counter=2. tick0 high only at counter=4,12,20,... (period 8). cfg_ready low at counter=2 only.
3. Burst ch1, tap=0, count=3, accepted at counter=10 -> tick1 at counter=11,13,15. done1 at counter=16. busy1 falls at 16.
4. Stop ch0 mid-run, then restart ch1 with count=5 on its 2nd tick -> ch0 ticks cease next cycle with no done. Ch1 emits 5 further ticks; only one done1.
5. Held cfg_valid for 4 cycles to ch0..ch3 -> accepts on cycles 0 and 2 only. cfg_ready pattern 1,0,1,0.
6. Assert reset_n=0 mid-burst at counter=0xFFFFFFF0 -> outputs clear immediately with no done. Separately, counter wrap FFFFFFFF->0 with tap=0 periodic shows no missing or extra tick.
